// File: rtl/mips_decls_p.sv
// Shared declarations for the multi-cycle MIPS core.
// Contents:
//   muldiv_op_t     operation select for the multiply/divide sequencer
//   muldiv_state_t  sequencer FSM states
//   funct_t         R-type funct codes for the HI/LO and mul/div instructions
package mips_decls_p;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } muldiv_state_t;

   typedef enum logic [5:0] {
      F_MFHI  = 6'h10,
      F_MTHI  = 6'h11,
      F_MFLO  = 6'h12,
      F_MTLO  = 6'h13,
      F_MULT  = 6'h18,
      F_MULTU = 6'h19,
      F_DIV   = 6'h1A,
      F_DIVU  = 6'h1B
   } funct_t;

endpackage

// File: rtl/md_iter_dp.sv
// Iterative multiply/divide datapath: 2*WIDTH shift register {acc_hi, acc_lo},
// a multiplicand/divisor register and one shared adder/subtractor.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            load opa into acc_lo, opb into opd, clear acc_hi
//   step            perform one shift-add (multiply) or shift-subtract (divide)
//   is_div          selects divide stepping and per-half sign correction
//   fix             applies sign correction on res_hi/res_lo
//   neg_hi, neg_lo  negate remainder/quotient (divide) or product (neg_lo, multiply)
//   opa, opb        unsigned magnitudes of the operands
//   res_hi, res_lo  current (optionally corrected) accumulator contents
module md_iter_dp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic             fix,
   input  logic             neg_hi,
   input  logic             neg_lo,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic [WIDTH-1:0]   acc_hi, acc_lo, opd;
   logic [WIDTH:0]     add_a, add_b;
   logic [WIDTH+1:0]   sum;
   logic [2*WIDTH-1:0] prod_neg;

   // Multiply: add the multiplicand into the upper half when the current
   // multiplier bit (acc_lo[0]) is set. Divide: the partial remainder shifted
   // left with the next dividend bit, minus the divisor (two's complement with
   // carry-in); the carry out of the extra top bit means "no borrow".
   assign add_a = is_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
   assign add_b = is_div ? ~{1'b0, opd} : (acc_lo[0] ? {1'b0, opd} : '0);
   assign sum   = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div};

   assign prod_neg = -{acc_hi, acc_lo};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_hi <= '0;
         acc_lo <= '0;
         opd    <= '0;
      end else if (load) begin
         acc_hi <= '0;
         acc_lo <= opa;
         opd    <= opb;
      end else if (step) begin
         if (is_div) begin
            if (sum[WIDTH+1]) begin
               acc_hi <= sum[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi <= add_a[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            {acc_hi, acc_lo} <= {sum[WIDTH:0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   // NOTE: outputs get a default before any conditional update so the block
   // stays purely combinational (no latch).
   always_comb begin
      res_hi = acc_hi;
      res_lo = acc_lo;
      if (fix) begin
         if (is_div) begin
            if (neg_hi) res_hi = -acc_hi;
            if (neg_lo) res_lo = -acc_lo;
         end else if (neg_lo) begin
            {res_hi, res_lo} = prod_neg;
         end
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer with HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU in a fixed WIDTH+3 cycles from the accepting edge
// and services MTHI/MTLO writes while idle. WIDTH must be >= 4 and even.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start, op           launch request and operation (accepted in IDLE/DONE)
//   srca, srcb          multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata   direct HI/LO writes
//   busy                high in PREP, ITER, FIX
//   done, divz          one-cycle completion pulse, divide-by-zero flag
//   hi, lo              HI/LO result registers
module muldiv_seq
   import mips_decls_p::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  muldiv_op_t       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             divz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   muldiv_state_t    state, state_nxt;
   logic [CW-1:0]    cnt;
   muldiv_op_t       op_r;
   logic [WIDTH-1:0] a_r, b_r, hi_r, lo_r;
   logic             neg_hi, neg_lo, divz_r;
   logic             is_div, is_signed, idle_like, accept, wr_ok;
   logic [WIDTH-1:0] a_abs, b_abs, dp_hi, dp_lo;

   // Any encoding other than MULT/DIV/DIVU falls through as MULTU.
   assign is_div    = (op_r == MD_DIV) || (op_r == MD_DIVU);
   assign is_signed = (op_r == MD_MULT) || (op_r == MD_DIV);

   assign idle_like = (state == IDLE) || (state == DONE);
   assign accept    = idle_like && start;
   // A start in the same cycle takes priority over HI/LO writes.
   assign wr_ok     = idle_like && !start;

   assign a_abs = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
   assign b_abs = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PREP;
         PREP:    state_nxt = ITER;
         ITER:    if (cnt == '0) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = start ? PREP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_r   <= MD_MULT;
         a_r    <= '0;
         b_r    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         neg_hi <= 1'b0;
         neg_lo <= 1'b0;
         divz_r <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_r <= op;
            a_r  <= srca;
            b_r  <= srcb;
         end
         if (wr_ok && mthi) hi_r <= wdata;
         if (wr_ok && mtlo) lo_r <= wdata;
         case (state)
            PREP: begin
               cnt    <= CW'(WIDTH - 1);
               divz_r <= is_div && (b_r == '0);
               // Quotient/product sign is the XOR of operand signs; the
               // remainder follows the dividend.
               neg_lo <= is_signed && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               neg_hi <= is_signed && (is_div ? a_r[WIDTH-1]
                                              : (a_r[WIDTH-1] ^ b_r[WIDTH-1]));
            end
            ITER: cnt <= cnt - 1'b1;
            FIX: begin
               // Divide-by-zero returns the raw dividend and an all-ones quotient.
               hi_r <= divz_r ? a_r : dp_hi;
               lo_r <= divz_r ? '1  : dp_lo;
            end
            default: ;
         endcase
      end
   end

   md_iter_dp #(.WIDTH(WIDTH)) u_dp (
      .clk    (clk),
      .reset  (reset),
      .load   (state == PREP),
      .step   (state == ITER),
      .is_div (is_div),
      .fix    (state == FIX),
      .neg_hi (neg_hi),
      .neg_lo (neg_lo),
      .opa    (a_abs),
      .opb    (b_abs),
      .res_hi (dp_hi),
      .res_lo (dp_lo)
   );

   assign busy = (state == PREP) || (state == ITER) || (state == FIX);
   assign done = (state == DONE);
   assign divz = (state == DONE) && divz_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32): directed corner cases plus
// random operations compared against a plain-arithmetic reference model.
module tb_muldiv_seq;
   import mips_decls_p::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, mthi, mtlo;
   muldiv_op_t   op;
   logic [W-1:0] srca, srcb, wdata;
   logic         busy, done, divz;
   logic [W-1:0] hi, lo;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_hi, exp_lo;
   logic         exp_z;

   always #5 clk = ~clk;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .srca  (srca),
      .srcb  (srcb),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .divz  (divz),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: MIPS HI/LO semantics straight from 64-bit arithmetic.
   task automatic model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic z);
      int          sa, sb;
      longint      ps;
      longint unsigned pu;
      sa = a;
      sb = b;
      z  = 1'b0;
      case (o)
         MD_MULT: begin
            ps = longint'(sa) * longint'(sb);
            {h, l} = ps;
         end
         MD_DIV: begin
            if (b == 0) begin
               z = 1'b1; h = a; l = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               l = a; h = 32'h0;
            end else begin
               l = sa / sb; h = sa % sb;
            end
         end
         MD_DIVU: begin
            if (b == 0) begin
               z = 1'b1; h = a; l = 32'hFFFF_FFFF;
            end else begin
               l = a / b; h = a % b;
            end
         end
         default: begin
            pu = {32'h0, a} * {32'h0, b};
            {h, l} = pu;
         end
      endcase
   endtask

   // Called at a negedge; the next posedge accepts. Returns at the negedge of cycle 1
   // with the operands scrambled to show they are not re-sampled.
   task automatic launch(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
      model(o, a, b, exp_hi, exp_lo, exp_z);
      op    = o;
      srca  = a;
      srcb  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op    = muldiv_op_t'($urandom_range(0, 3));
      srca  = $urandom();
      srcb  = $urandom();
   endtask

   task automatic wait_done(input string tag, input int cyc0);
      int cyc = cyc0;
      bit busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 80) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'd35);
      check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
      check({tag, " busy_in_done"}, {31'b0, busy}, 32'd0);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
      check({tag, " divz"}, {31'b0, divz}, {31'b0, exp_z});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         4:       return -32'($urandom_range(1, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int n_done;
      reset = 1'b0;
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      op    = MD_MULTU;
      srca  = '0;
      srcb  = '0;
      wdata = '0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset divz", {31'b0, divz}, 32'd0);
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Directed cases
      launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu_max", 1);
      check("multu_max hi const", hi, 32'hFFFF_FFFE);
      check("multu_max lo const", lo, 32'h0000_0001);
      @(negedge clk);
      check("done one pulse", {31'b0, done}, 32'd0);

      launch(MD_MULT, -32'd3, 32'd7);        wait_done("mult_neg", 1);
      check("mult_neg lo const", lo, 32'hFFFF_FFEB);
      launch(MD_DIVU, 32'd100, 32'd7);       wait_done("divu", 1);
      launch(MD_DIV, -32'd7, 32'd2);         wait_done("div_negdvd", 1);
      check("div_negdvd hi const", hi, 32'hFFFF_FFFF);
      launch(MD_DIV, 32'd7, -32'd2);         wait_done("div_negdvs", 1);
      launch(MD_DIVU, 32'd5, 32'd0);         wait_done("divu_zero", 1);
      check("divu_zero divz const", {31'b0, divz}, 32'd1);
      launch(MD_DIV, -32'd9, 32'd0);         wait_done("div_zero", 1);
      launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 1);

      // HI/LO writes while idle, both at once
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_0001;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      check("mthi_mtlo hi", hi, 32'h5A5A_0001);
      check("mthi_mtlo lo", lo, 32'h5A5A_0001);

      // Start wins over a simultaneous mtlo
      mtlo = 1'b1; wdata = 32'h0BAD_0BAD;
      launch(MD_MULTU, 32'd6, 32'd7);
      mtlo = 1'b0;
      check("start_wins lo", lo, 32'h5A5A_0001);
      wait_done("start_wins", 1);

      // Start during ITER ignored; mthi while busy dropped
      @(negedge clk);
      launch(MD_MULTU, 32'hDEAD_BEEF, 32'h0001_0003);
      repeat (9) @(negedge clk);
      start = 1'b1; op = MD_DIVU; srca = 32'd1; srcb = 32'd1;
      @(negedge clk);
      start = 1'b0; mthi = 1'b1; wdata = 32'h0000_1234;
      @(negedge clk);
      mthi = 1'b0;
      wait_done("ignore_start", 12);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("no_second_done", 32'(n_done), 32'd0);

      // Back-to-back: start presented in DONE
      @(negedge clk);
      launch(MD_DIV, 32'h7FFF_FFFF, -32'd3);
      wait_done("b2b_first", 1);
      launch(MD_MULT, 32'h8000_0000, 32'h8000_0000);
      wait_done("b2b_second", 1);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         launch(muldiv_op_t'($urandom_range(0, 3)), pick(), pick());
         wait_done($sformatf("rand%0d", i), 1);
      end

      // Asynchronous reset in ITER
      @(negedge clk);
      launch(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_iter busy", {31'b0, busy}, 32'd0);
      check("rst_iter done", {31'b0, done}, 32'd0);
      check("rst_iter hi", hi, 32'h0);
      check("rst_iter lo", lo, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("rst_no_done", 32'(n_done), 32'd0);
      mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      mtlo = 1'b0;
      check("post_rst mtlo", lo, 32'hA5A5_A5A5);
      check("post_rst hi", hi, 32'h0);
      launch(MD_MULTU, 32'd3, 32'd4);
      wait_done("post_rst_multu", 1);
      check("post_rst_multu lo const", lo, 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
